s2_conv_sequencer: RTL

Control and collection block for the stage-2 convolution datapath. Drives the filter select (`proc_dir`) and window position (`proc_counter`) into the combinational stage-2 tensor processing unit. Captures the single valid ReLU result it returns each cycle into a 144-entry feature-map register file (4 filters × 36 positions). Exposes that file to stage 3 through a start/done handshake and a registered read port.

---
 rtl/s2_conv_sequencer_if.sv | 28 ++
 rtl/s2_conv_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/s2_conv_sequencer_if.sv
// Bus bundle between the stage-2 sequencer, the stage-2 processing unit and
// stage 3. The slave side is the sequencer itself; the master side is the
// environment (control, processing unit, stage-3 reader).
interface s2_conv_sequencer_if #(
  parameter int NFILT  = 4,
  parameter int NPOS   = 36,
  parameter int DWIDTH = 35
);
  logic                                       start;
  logic                                       stall;
  logic                                       busy;
  logic                                       done;
  logic [1:0]                                 proc_dir;
  logic [5:0]                                 proc_counter;
  logic signed [NFILT*NPOS-1:0][DWIDTH-1:0]   output_res;
  logic [7:0]                                 rd_addr;
  logic signed [DWIDTH-1:0]                   rd_data;

  modport master (
    output start, stall, output_res, rd_addr,
    input  busy, done, proc_dir, proc_counter, rd_data
  );

  modport slave (
    input  start, stall, output_res, rd_addr,
    output busy, done, proc_dir, proc_counter, rd_data
  );
endinterface

// File: rtl/s2_conv_sequencer.sv
// Stage-2 convolution sequencer: sweeps filter/position indices into the
// processing unit, captures the one selected result per cycle into a
// feature-map register file and serves it to stage 3 via a registered port.
module s2_conv_sequencer #(
  parameter int NFILT  = 4,
  parameter int NPOS   = 36,
  parameter int DWIDTH = 35
) (
  input  logic                 clk,
  input  logic                 rst,
  s2_conv_sequencer_if.slave   bus
);
  localparam int DEPTH = NFILT * NPOS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_reg;
  state_t                    state_next;
  logic [1:0]                dir_reg;
  logic [5:0]                cnt_reg;
  logic signed [DWIDTH-1:0]  fmap_reg [DEPTH];
  logic signed [DWIDTH-1:0]  rd_data_reg;

  logic                      clear_en;
  logic                      capture_en;
  logic                      busy;
  logic                      done;
  logic                      last_pos;
  logic                      cnt_wrap;
  logic [7:0]                wr_idx;

  // The capture index comes from our own registers, never from the result
  // vector, so garbage in non-selected entries cannot leak into the map.
  assign wr_idx   = 8'(dir_reg) * 8'(NPOS) + 8'(cnt_reg);
  assign cnt_wrap = (cnt_reg == 6'(NPOS - 1));
  assign last_pos = (dir_reg == 2'(NFILT - 1)) && cnt_wrap;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and control decode; start is only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    clear_en   = 1'b0;
    capture_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          clear_en   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (!bus.stall) begin
          capture_en = 1'b1;
          if (last_pos) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sweep position counters; the final increment wraps dir back to 0, so
  // the indices are already zero by the time DONE is reached.
  always_ff @(posedge clk) begin
    if (rst || clear_en) begin
      dir_reg <= '0;
      cnt_reg <= '0;
    end else if (capture_en) begin
      if (cnt_wrap) begin
        cnt_reg <= '0;
        dir_reg <= dir_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 6'd1;
      end
    end
  end

  // Feature-map file: bulk clear on reset/start, single-entry capture in
  // RUN, and a registered read that sees the pre-write value on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fmap_reg[i] <= '0;
      rd_data_reg <= '0;
    end else begin
      if (clear_en) begin
        for (int i = 0; i < DEPTH; i++) fmap_reg[i] <= '0;
      end else if (capture_en) begin
        fmap_reg[wr_idx] <= $signed(bus.output_res[wr_idx]);
      end
      if (bus.rd_addr < 8'(DEPTH)) rd_data_reg <= fmap_reg[bus.rd_addr];
      else                         rd_data_reg <= '0;
    end
  end

  assign bus.proc_dir     = dir_reg;
  assign bus.proc_counter = cnt_reg;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.rd_data      = rd_data_reg;
endmodule
